// File: rtl/ckx_pkg.sv
// Shared types and constants for the chaos key extractor.
package ckx_pkg;

  localparam int KEY_W   = 16;
  localparam int DBL_W   = 64;
  localparam int EXP_MSB = 62;
  localparam int EXP_LSB = 52;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BURN = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } ckx_state_t;

  typedef struct packed {
    logic [KEY_W-1:0] key_x;
    logic [KEY_W-1:0] key_y;
    logic [KEY_W-1:0] key_z;
  } key_triple_t;

  // An all-ones exponent marks Inf or NaN.
  function automatic logic is_nonfinite(input logic [DBL_W-1:0] v);
    return &v[EXP_MSB:EXP_LSB];
  endfunction

endpackage

// File: rtl/ckx_fifo.sv
// First-word fall-through FIFO of key triples. The head entry is visible
// on dout whenever empty is low; pushes into a full FIFO and pops from an
// empty one are ignored. level_next exposes the post-edge occupancy so the
// parent can register flow-control signals without a cycle of slack.
module ckx_fifo
  import ckx_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  key_triple_t                din,
  input  logic                       pop,
  output key_triple_t                dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level,
  output logic [$clog2(DEPTH):0]     level_next
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  key_triple_t        mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q,  level_d;
  logic               push_ok, pop_ok;

  assign full    = (level_q == LVL_W'(DEPTH));
  assign empty   = (level_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];
  assign level   = level_q;
  assign level_next = level_d;

  // Pointer and occupancy update; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
    level_d  = level_q + LVL_W'(push_ok) - LVL_W'(pop_ok);
  end

  // Pointer/level registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/chaos_key_extractor.sv
// Chaos key extractor: discards BURN_IN integrator triples, then slices
// each following (x,y,z) double into three 16-bit key words and queues
// them in a FWFT FIFO for the confusion/diffusion engine.
// Optional feature macro: CKX_NONFINITE_DROP_EN -- drops Inf/NaN triples
// in RUN and adds a sticky err_flag output.
module chaos_key_extractor
  import ckx_pkg::*;
#(
  parameter int BURN_IN    = 16,
  parameter int NUM_KEYS   = 65536,
  parameter int WORD_LSB   = 0,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        sample_valid,
  output logic        sample_ready,
  input  logic [63:0] sample_x,
  input  logic [63:0] sample_y,
  input  logic [63:0] sample_z,
  output logic        key_valid,
  input  logic        key_ready,
  output logic [15:0] key_x,
  output logic [15:0] key_y,
  output logic [15:0] key_z,
  output logic [16:0] key_count,
  output logic        busy,
`ifdef CKX_NONFINITE_DROP_EN
  output logic        err_flag,
`endif
  output logic        done
);

  localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int BCNT_W = (BURN_IN > 0) ? $clog2(BURN_IN + 1) : 1;

  ckx_state_t        state_q, state_d;
  logic [BCNT_W-1:0] burn_cnt_q, burn_cnt_d;
  logic [16:0]       key_count_q, key_count_d;
  logic              sample_ready_q, sample_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              accept, push, drop;
  key_triple_t       new_key, head;
  logic              fifo_full, fifo_empty;
  logic [LVL_W-1:0]  fifo_level, fifo_level_next;

  // Double bits outside the key window are intentionally unused.
  logic              unused_bits;
  assign unused_bits = ^{sample_x, sample_y, sample_z, fifo_full, fifo_level};

  assign accept = sample_valid && sample_ready_q;

  // Raw bit slice of each coordinate, no float interpretation.
  assign new_key.key_x = sample_x[WORD_LSB +: KEY_W];
  assign new_key.key_y = sample_y[WORD_LSB +: KEY_W];
  assign new_key.key_z = sample_z[WORD_LSB +: KEY_W];

`ifdef CKX_NONFINITE_DROP_EN
  logic err_q, err_d;
  assign drop = accept && (state_q == RUN) &&
                (is_nonfinite(sample_x) || is_nonfinite(sample_y) || is_nonfinite(sample_z));
  assign err_flag = err_q;
`else
  assign drop = 1'b0;
`endif

  assign push = accept && (state_q == RUN) && !drop;

  ckx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .din        (new_key),
    .pop        (key_ready),
    .dout       (head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .level      (fifo_level),
    .level_next (fifo_level_next)
  );

  // Head is masked to zero when empty so outputs are clean after reset.
  assign key_valid    = !fifo_empty;
  assign key_x        = fifo_empty ? '0 : head.key_x;
  assign key_y        = fifo_empty ? '0 : head.key_y;
  assign key_z        = fifo_empty ? '0 : head.key_z;
  assign key_count    = key_count_q;
  assign sample_ready = sample_ready_q;
  assign busy         = busy_q;
  assign done         = done_q;

  // Next-state, counters, and registered status computed from the
  // post-edge state and FIFO level.
  always_comb begin
    state_d     = state_q;
    burn_cnt_d  = burn_cnt_q;
    key_count_d = key_count_q;
`ifdef CKX_NONFINITE_DROP_EN
    err_d       = err_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = (BURN_IN > 0) ? BURN : RUN;
          burn_cnt_d  = '0;
          key_count_d = '0;
`ifdef CKX_NONFINITE_DROP_EN
          err_d       = 1'b0;
`endif
        end
      end
      BURN: begin
        if (accept) begin
          burn_cnt_d = burn_cnt_q + 1'b1;
          if (burn_cnt_q == BCNT_W'(BURN_IN - 1)) state_d = RUN;
        end
      end
      RUN: begin
        if (push && key_count_q != 17'(NUM_KEYS)) begin
          key_count_d = key_count_q + 17'd1;
          if (key_count_q == 17'(NUM_KEYS - 1)) state_d = DONE;
        end
`ifdef CKX_NONFINITE_DROP_EN
        if (drop) err_d = 1'b1;
`endif
      end
      default: state_d = IDLE;
    endcase

    sample_ready_d = (state_d == BURN) ||
                     ((state_d == RUN) && (fifo_level_next != LVL_W'(FIFO_DEPTH)));
    busy_d         = (state_d == BURN) || (state_d == RUN) || (fifo_level_next != '0);
    done_d         = (state_d == DONE) && (fifo_level_next == '0);
  end

  // Control registers; synchronous reset has priority over start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      burn_cnt_q     <= '0;
      key_count_q    <= '0;
      sample_ready_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      burn_cnt_q     <= burn_cnt_d;
      key_count_q    <= key_count_d;
      sample_ready_q <= sample_ready_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

`ifdef CKX_NONFINITE_DROP_EN
  // Sticky non-finite drop indicator.
  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end
`endif

endmodule

// File: tb/tb_chaos_key_extractor.sv
// Randomized self-checking bench for chaos_key_extractor with a queue-based
// behavioural model plus directed literal checks.
module tb_chaos_key_extractor;

  localparam int BURN_IN  = 2;
  localparam int NUM_KEYS = 40;
  localparam int WORD_LSB = 0;
  localparam int DEPTH    = 8;

  localparam int S_IDLE = 0, S_BURN = 1, S_RUN = 2, S_DONE = 3;

  logic        clk = 1'b0;
  logic        reset, start, sample_valid, key_ready;
  logic [63:0] sx, sy, sz;
  logic        sample_ready, key_valid, busy, done;
  logic [15:0] key_x, key_y, key_z;
  logic [16:0] key_count;
`ifdef CKX_NONFINITE_DROP_EN
  logic        err_flag;
`endif

  chaos_key_extractor #(
    .BURN_IN(BURN_IN), .NUM_KEYS(NUM_KEYS), .WORD_LSB(WORD_LSB), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .sample_x(sx), .sample_y(sy), .sample_z(sz),
    .key_valid(key_valid), .key_ready(key_ready),
    .key_x(key_x), .key_y(key_y), .key_z(key_z),
    .key_count(key_count), .busy(busy),
`ifdef CKX_NONFINITE_DROP_EN
    .err_flag(err_flag),
`endif
    .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int          m_st = S_IDLE;
  int          m_burned = 0;
  int          m_kcnt = 0;
  logic [47:0] m_q[$];
  bit          m_ready = 0, m_busy = 0, m_done = 0, m_err = 0;

  function automatic logic [15:0] wrd(input logic [63:0] v);
    return 16'((v >> WORD_LSB) & 64'hFFFF);
  endfunction

  function automatic bit nonfin(input logic [63:0] v);
    return ((v >> 52) & 64'h7FF) == 64'h7FF;
  endfunction

  function automatic logic [63:0] rnd_dbl();
    logic [63:0] v;
    v = {$urandom, $urandom};
    v[62] = 1'b0;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    bit acc, popk, drp;
    acc  = sample_valid && m_ready;
    popk = key_ready && (m_q.size() > 0);
    if (reset) begin
      m_st = S_IDLE; m_burned = 0; m_kcnt = 0; m_q.delete(); m_err = 0;
    end else begin
      if (popk) void'(m_q.pop_front());
      case (m_st)
        S_IDLE, S_DONE:
          if (start) begin
            m_st = (BURN_IN > 0) ? S_BURN : S_RUN;
            m_burned = 0; m_kcnt = 0; m_err = 0;
          end
        S_BURN:
          if (acc) begin
            m_burned++;
            if (m_burned == BURN_IN) m_st = S_RUN;
          end
        S_RUN:
          if (acc) begin
            drp = 0;
`ifdef CKX_NONFINITE_DROP_EN
            drp = nonfin(sx) || nonfin(sy) || nonfin(sz);
`endif
            if (drp) m_err = 1;
            else begin
              m_q.push_back({wrd(sx), wrd(sy), wrd(sz)});
              m_kcnt++;
              if (m_kcnt == NUM_KEYS) m_st = S_DONE;
            end
          end
        default: ;
      endcase
    end
    m_ready = (m_st == S_BURN) || (m_st == S_RUN && m_q.size() < DEPTH);
    m_busy  = (m_st == S_BURN) || (m_st == S_RUN) || (m_q.size() > 0);
    m_done  = (m_st == S_DONE) && (m_q.size() == 0);
  endtask

  task automatic compare_all();
    logic [47:0] h;
    h = (m_q.size() > 0) ? m_q[0] : 48'h0;
    chk("sample_ready", sample_ready, m_ready);
    chk("key_valid",    key_valid,    m_q.size() > 0);
    chk("key_x",        key_x,        h[47:32]);
    chk("key_y",        key_y,        h[31:16]);
    chk("key_z",        key_z,        h[15:0]);
    chk("key_count",    key_count,    m_kcnt);
    chk("busy",         busy,         m_busy);
    chk("done",         done,         m_done);
`ifdef CKX_NONFINITE_DROP_EN
    chk("err_flag",     err_flag,     m_err);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    int acc_n;
    logic [63:0] nan_y;
    nan_y = 64'h7FF8000000000000;
    reset = 1; start = 0; sample_valid = 0; key_ready = 0;
    sx = '0; sy = '0; sz = '0;

    // Reset state
    repeat (3) tick();
    chk("rst_key_valid", key_valid, 0);
    chk("rst_ready", sample_ready, 0);
    chk("rst_count", key_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 0;

    // Burn-in then keys from a fixed x
    start = 1; tick(); start = 0;
    sample_valid = 1; key_ready = 1; sx = 64'h4019058A7000CFFC;
    for (int i = 0; i < 8; i++) begin
      sy = rnd_dbl(); sz = rnd_dbl();
      tick();
      if (key_valid) chk("burn_key_x", key_x, 16'hCFFC);
    end
    chk("burn_count", key_count, 6);

    // Drain, then back-pressure: exactly DEPTH pushes
    sample_valid = 0; repeat (3) tick();
    key_ready = 0; sample_valid = 1; acc_n = 0;
    for (int i = 0; i < 12; i++) begin
      sx = rnd_dbl(); sy = rnd_dbl(); sz = rnd_dbl();
      if (sample_ready) acc_n++;
      tick();
    end
    chk("full_pushes", acc_n, 8);
    chk("full_ready_low", sample_ready, 0);
    key_ready = 1; tick(); key_ready = 0;
    acc_n = 0;
    for (int i = 0; i < 6; i++) begin
      if (sample_ready) acc_n++;
      tick();
    end
    chk("one_pop_one_push", acc_n, 1);
    chk("bp_count", key_count, 15);

    // Bring level to 4, then push+pop together for 10 cycles; start ignored
    sample_valid = 0; key_ready = 1;
    for (int i = 0; i < 10 && m_q.size() != 4; i++) tick();
    sample_valid = 1;
    for (int i = 0; i < 10; i++) begin
      start = (i == 0);
      sx = rnd_dbl(); sy = rnd_dbl(); sz = rnd_dbl();
      tick();
      chk("steady_ready", sample_ready, 1);
    end
    start = 0;
    chk("steady_count", key_count, 25);

    // Non-finite y in RUN
    sample_valid = 0; repeat (10) tick();
    key_ready = 0; sample_valid = 1; sy = nan_y; sx = rnd_dbl(); sz = rnd_dbl();
    chk("nan_ready", sample_ready, 1);
    tick();
    sample_valid = 0;
`ifdef CKX_NONFINITE_DROP_EN
    chk("nan_no_push", key_valid, 0);
    chk("nan_count", key_count, 25);
    chk("nan_err", err_flag, 1);
`else
    chk("nan_push", key_valid, 1);
    chk("nan_key_y", key_y, 16'h0000);
    chk("nan_count", key_count, 26);
`endif

    // Reset mid-run with keys buffered
    sample_valid = 1;
    repeat (3) begin sx = rnd_dbl(); sy = rnd_dbl(); sz = rnd_dbl(); tick(); end
    sample_valid = 0; reset = 1; tick(); reset = 0;
    chk("mid_rst_valid", key_valid, 0);
    chk("mid_rst_count", key_count, 0);
    chk("mid_rst_ready", sample_ready, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      sample_valid = ($urandom_range(3) != 0);
      key_ready    = ($urandom_range(3) != 0);
      start        = ($urandom_range(29) == 0);
      reset        = ($urandom_range(399) == 0);
      sx = rnd_dbl(); sz = rnd_dbl();
      sy = ($urandom_range(15) == 0) ? nan_y : rnd_dbl();
      tick();
    end

    // Full run to completion, then a restart from DONE
    start = 0; reset = 1; tick(); reset = 0;
    start = 1; tick(); start = 0;
    sample_valid = 1; key_ready = 1;
    for (int i = 0; i < 300 && !done; i++) begin
      sx = rnd_dbl(); sy = rnd_dbl(); sz = rnd_dbl();
      tick();
    end
    chk("final_done", done, 1);
    chk("final_count", key_count, NUM_KEYS);
    start = 1; tick(); start = 0;
    chk("restart_done", done, 0);
    chk("restart_count", key_count, 0);
    chk("restart_busy", busy, 1);
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
